// File: rtl/fsk_rx_pkg.sv
// fsk_rx_pkg
//   Shared types and default constants for the FSK receive frame controller.
//   Contents:
//     rx_state_t      frame controller state encoding
//     *_DEF           default parameter values for the controller
//   Optional feature macro: FSK_RX_PARITY_EN adds the PARITY state.
package fsk_rx_pkg;

    localparam int BIT_CYCLES_DEF = 200;
    localparam int DATA_W_DEF     = 8;
    localparam int CARRIER_TO_DEF = 64;

    // Three bits in both builds so the encoding of the common states is
    // identical with and without the parity state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef FSK_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/fsk_bit_timer.sv
// fsk_bit_timer
//   Bit-period timer for the FSK frame controller. Counts clock cycles from
//   the last clear and flags the mid-start-bit and full-bit-period points.
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     clr        synchronous clear, count restarts at 0 next cycle
//     half_tick  high while count == BIT_CYCLES/2-1
//     full_tick  high while count == BIT_CYCLES-1
module fsk_bit_timer #(
    parameter int CNT_W      = 8,
    parameter int BIT_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // The count wraps to 0 after BIT_CYCLES-1 so it can never run past the
    // bit period even if the controller does not clear it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == HALF_CNT);
    assign full_tick = (cnt == LAST_CNT);

endmodule

// File: rtl/fsk_rx_frame_ctrl.sv
// fsk_rx_frame_ctrl
//   Frame controller behind the FSK demodulator. Detects start bits, samples
//   each bit in the middle of its period, assembles LSB-first bytes, checks
//   the stop bit and hands bytes out over a valid/ready handshake. Frames are
//   abandoned when the carrier (zero-crossing strobes) disappears.
//   Ports:
//     clk, rst     system clock, synchronous active-high reset
//     enable       0 forces IDLE and drops any frame in progress
//     bit_in       demodulated bit level (mark/idle = 1)
//     edge_in      one-cycle zero-crossing strobe
//     data_out     received byte, stable while data_valid
//     data_valid   data_out holds an unread byte
//     data_ready   consumer takes the byte when data_valid && data_ready
//     framing_err  one-cycle pulse, stop bit sampled as 0
//     overrun      one-cycle pulse, finished byte dropped (holding reg full)
//     carrier_ok   zero-crossings seen recently
//     busy         controller is inside a frame
//     parity_err   (FSK_RX_PARITY_EN only) one-cycle pulse, even parity failed
//   Optional feature macro: FSK_RX_PARITY_EN inserts an even-parity bit
//   between the data bits and the stop bit.
module fsk_rx_frame_ctrl
    import fsk_rx_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CARRIER_TO = CARRIER_TO_DEF,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              bit_in,
    input  logic              edge_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              framing_err,
    output logic              overrun,
    output logic              carrier_ok,
    output logic              busy
`ifdef FSK_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CARRIER_LIMIT = CNT_W'(CARRIER_TO);

    rx_state_t         state;
    logic [CNT_W-1:0]  carrier_cnt;
    logic              prev_bit;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              timer_clr;
    logic              half_tick;
    logic              full_tick;
    logic              abort;
    logic              par_fail;
    logic              byte_done;

`ifdef FSK_RX_PARITY_EN
    logic              par_bit;

    assign par_fail = ^{shreg, par_bit};
`else
    assign par_fail = 1'b0;
`endif

    assign abort = !enable || !carrier_ok;

    // A byte is delivered only from a clean stop-bit sample that is not
    // overridden by an abort in the same cycle.
    assign byte_done = (state == STOP) && !abort && full_tick && bit_in && !par_fail;

    fsk_bit_timer #(
        .CNT_W      (CNT_W),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // The timer is held at zero in IDLE so START always begins from a fresh
    // count, and is restarted at every sample point inside a frame.
    always_comb begin
        timer_clr = 1'b0;
        case (state)
            IDLE:    timer_clr = 1'b1;
            START:   timer_clr = half_tick;
            DATA:    timer_clr = full_tick;
`ifdef FSK_RX_PARITY_EN
            PARITY:  timer_clr = full_tick;
`endif
            STOP:    timer_clr = full_tick;
            default: timer_clr = 1'b1;
        endcase
    end

    // Carrier monitor: every strobe restarts the silence counter, which
    // saturates at the timeout and then drops carrier_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_cnt <= '0;
            carrier_ok  <= 1'b0;
        end else if (edge_in) begin
            carrier_cnt <= '0;
            carrier_ok  <= 1'b1;
        end else if (carrier_cnt == CARRIER_LIMIT) begin
            carrier_ok  <= 1'b0;
        end else begin
            carrier_cnt <= carrier_cnt + 1'b1;
        end
    end

    // One-cycle history of the line so a start needs a real 1->0 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_bit <= 1'b1;
        end else begin
            prev_bit <= bit_in;
        end
    end

    // Frame FSM. Abort has priority over any sample point so a frame that
    // loses carrier or enable never raises a flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            framing_err <= 1'b0;
`ifdef FSK_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
`ifdef FSK_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && carrier_ok && prev_bit && !bit_in) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (half_tick) begin
                            if (!bit_in) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (full_tick) begin
                            shreg[bit_idx] <= bit_in;
                            if (bit_idx == LAST_IDX) begin
`ifdef FSK_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
`ifdef FSK_RX_PARITY_EN
                    PARITY: begin
                        if (full_tick) begin
                            par_bit <= bit_in;
                            state   <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (full_tick) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            framing_err <= !bit_in;
`ifdef FSK_RX_PARITY_EN
                            parity_err  <= par_fail;
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register. A completed byte may replace the held one only if
    // the consumer takes the old one in the same cycle; otherwise it is
    // dropped and flagged so data_out never changes under data_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
